// File: rtl/mem_arbiter_if.sv
// Bundles the I-cache, D-cache and physical-memory handshake signals.
// The arbiter uses the slave modport; caches and memory models use the master modport.
interface mem_arbiter_if #(
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned LINE_WIDTH = 128
);
   logic                  i_read;
   logic [ADDR_WIDTH-1:0] i_address;
   logic [LINE_WIDTH-1:0] i_rdata;
   logic                  i_resp;

   logic                  d_read;
   logic                  d_write;
   logic [ADDR_WIDTH-1:0] d_address;
   logic [LINE_WIDTH-1:0] d_wdata;
   logic [LINE_WIDTH-1:0] d_rdata;
   logic                  d_resp;

   logic                  pmem_read;
   logic                  pmem_write;
   logic [ADDR_WIDTH-1:0] pmem_address;
   logic [LINE_WIDTH-1:0] pmem_wdata;
   logic [LINE_WIDTH-1:0] pmem_rdata;
   logic                  pmem_resp;

   modport slave (
      input  i_read, i_address, d_read, d_write, d_address, d_wdata, pmem_rdata, pmem_resp,
      output i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_address, pmem_wdata
   );

   modport master (
      output i_read, i_address, d_read, d_write, d_address, d_wdata, pmem_rdata, pmem_resp,
      input  i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_address, pmem_wdata
   );
endinterface

// File: rtl/mem_arbiter.sv
// Shares the pmem port between I-cache and D-cache, one 128-bit line access at a time.
// Define ARB_ROUND_ROBIN_EN for round-robin contention instead of D priority with starvation guard.
module mem_arbiter #(
   parameter int unsigned ADDR_WIDTH   = 16,
   parameter int unsigned LINE_WIDTH   = 128,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input logic          clk,
   input logic          rst_n,
   mem_arbiter_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StIBusy, StDRd, StDWr} state_e;

   state_e                r_state, w_state_d;
   logic [ADDR_WIDTH-1:0] r_addr, w_addr_d;
   logic [LINE_WIDTH-1:0] r_wdata, w_wdata_d;
   logic                  w_d_req;
   logic                  w_grant_d;
   logic                  w_grant_i;

   assign w_d_req = bus.d_read | bus.d_write;

`ifdef ARB_ROUND_ROBIN_EN
   logic r_last_d, w_last_d_d;

   assign w_grant_d = w_d_req & (~bus.i_read | ~r_last_d);
`else
   localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

   logic [3:0] r_starve_cnt, w_starve_cnt_d;

   // D wins contention until I has watched StarveMax consecutive D grants.
   assign w_grant_d = w_d_req & (~bus.i_read | (r_starve_cnt != StarveMax));
`endif

   assign w_grant_i = bus.i_read & ~w_grant_d;

   always_comb begin
      w_state_d = r_state;
      w_addr_d  = r_addr;
      w_wdata_d = r_wdata;
`ifdef ARB_ROUND_ROBIN_EN
      w_last_d_d = r_last_d;
`else
      w_starve_cnt_d = r_starve_cnt;
`endif
      unique case (r_state)
         StIdle: begin
            if (w_grant_d) begin
               w_addr_d = bus.d_address;
               if (bus.d_write) begin
                  w_state_d = StDWr;
                  w_wdata_d = bus.d_wdata;
               end else begin
                  w_state_d = StDRd;
               end
`ifdef ARB_ROUND_ROBIN_EN
               w_last_d_d = 1'b1;
`else
               if (!bus.i_read) begin
                  w_starve_cnt_d = 4'd0;
               end else if (r_starve_cnt != StarveMax) begin
                  w_starve_cnt_d = r_starve_cnt + 4'd1;
               end
`endif
            end else if (w_grant_i) begin
               w_state_d = StIBusy;
               w_addr_d  = bus.i_address;
`ifdef ARB_ROUND_ROBIN_EN
               w_last_d_d = 1'b0;
`else
               w_starve_cnt_d = 4'd0;
`endif
            end
         end
         StIBusy, StDRd, StDWr: begin
            if (bus.pmem_resp) begin
               w_state_d = StIdle;
            end
         end
         default: w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= StIdle;
         r_addr  <= '0;
         r_wdata <= '0;
`ifdef ARB_ROUND_ROBIN_EN
         r_last_d <= 1'b0;
`else
         r_starve_cnt <= 4'd0;
`endif
      end else begin
         r_state <= w_state_d;
         r_addr  <= w_addr_d;
         r_wdata <= w_wdata_d;
`ifdef ARB_ROUND_ROBIN_EN
         r_last_d <= w_last_d_d;
`else
         r_starve_cnt <= w_starve_cnt_d;
`endif
      end
   end

   // Responses are combinational so the owner sees pmem_resp in the same cycle.
   assign bus.pmem_read    = (r_state == StIBusy) || (r_state == StDRd);
   assign bus.pmem_write   = (r_state == StDWr);
   assign bus.pmem_address = r_addr;
   assign bus.pmem_wdata   = r_wdata;
   assign bus.i_resp       = (r_state == StIBusy) && bus.pmem_resp;
   assign bus.d_resp       = ((r_state == StDRd) || (r_state == StDWr)) && bus.pmem_resp;
   assign bus.i_rdata      = bus.pmem_rdata;
   assign bus.d_rdata      = bus.pmem_rdata;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single physical-memory port between the instruction-fetch cache (I-side) and the data cache (D-side). The D-side carries the load/store addresses produced in the execute stage.
- Accepts one 128-bit line request at a time, forwards it to memory, and routes the response back to the owning requester.
- Sits between the L1 caches and pmem; contains an FSM, registered address/data capture and a starvation counter.

Parameters:
- ADDR_WIDTH, 16, width of line addresses (lc3b_word).
- LINE_WIDTH, 128, cache line width in bits.
- STARVE_LIMIT, 4, consecutive D grants allowed while I is waiting before I is forced next; range 1..15.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- i_read  in  1  I-side line read request; held until i_resp.
- i_address  in  ADDR_WIDTH  I-side line address.
- i_rdata  out  LINE_WIDTH  line returned to I-side.
- i_resp  out  1  one-cycle completion pulse to I-side.
- d_read  in  1  D-side line read request; held until d_resp.
- d_write  in  1  D-side line write-back request; held until d_resp.
- d_address  in  ADDR_WIDTH  D-side line address.
- d_wdata  in  LINE_WIDTH  D-side write-back line.
- d_rdata  out  LINE_WIDTH  line returned to D-side.
- d_resp  out  1  one-cycle completion pulse to D-side.
- pmem_read  out  1  memory read strobe, held until pmem_resp.
- pmem_write  out  1  memory write strobe, held until pmem_resp.
- pmem_address  out  ADDR_WIDTH  memory address (registered).
- pmem_wdata  out  LINE_WIDTH  memory write data (registered).
- pmem_rdata  in  LINE_WIDTH  memory read data, valid with pmem_resp.
- pmem_resp  in  1  memory completion.

Behaviour:
- Reset: when rst_n=0 at a clock edge:
  - state goes to IDLE; starve_cnt=0; last_grant=I.
  - pmem_read, pmem_write, i_resp and d_resp all 0; pmem_address=0, pmem_wdata=0.
  - Reset mid-transaction abandons the access; a later pmem_resp seen in IDLE is ignored.
- States:
  - IDLE: no pmem strobe. Requests are sampled only here.
  - I_BUSY: pmem_read=1.
  - D_RD: pmem_read=1.
  - D_WR: pmem_write=1.
- IDLE arbitration, at each edge:
  - Only D requesting -> D. Only I requesting -> I.
  - Both requesting -> D, unless starve_cnt==STARVE_LIMIT, in which case I.
  - No request -> stay in IDLE.
- Grant actions:
  - Address (and d_wdata for writes) is captured into pmem_address/pmem_wdata.
  - Next state is I_BUSY, D_RD or D_WR.
  - If d_read and d_write are both 1, the write wins (D_WR).
- Latency: request sampled at edge N -> pmem strobe high during cycle N+1.
- Busy state with pmem_resp=1:
  - The owner's x_resp=1 in that same cycle, combinationally.
  - For reads, x_rdata=pmem_rdata in that same cycle.
  - Next state is IDLE; the strobe drops.
  - Minimum turnaround is one IDLE cycle between transactions.
- Requester rule: deassert the request in the cycle after x_resp, otherwise it is re-granted.
- i_rdata/d_rdata: pass pmem_rdata through; contents are don't-care when the matching resp=0.
- Starvation counter, updated on each grant:
  - D granted while i_read=1 -> starve_cnt+1, saturating at STARVE_LIMIT.
  - I granted, or D granted with i_read=0 -> starve_cnt=0.
- pmem_resp outside a busy state is ignored; no resp pulse is generated.
- A request change while busy is not observed until IDLE.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined:
  - Contention in IDLE grants the side opposite last_grant.
  - last_grant updates on every grant.
  - starve_cnt logic is removed; STARVE_LIMIT is unused.
- Undefined: fixed D priority with the starvation override above.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with i_read=1 and d_write=1 -> all strobes and resps 0, pmem_address=0. Release -> D_WR granted first.
- Lone I read, i_address=0x1230, memory responds after 3 cycles with 0xDEAD...BEEF:
  - pmem_read rises 1 cycle after the request and pmem_address=0x1230.
  - i_resp is one pulse with i_rdata matching; d_resp stays 0.
- D write-back, d_address=0x8000, d_wdata=0xA5 repeated:
  - pmem_write=1 with the captured data.
  - Changing d_wdata mid-transaction does not alter pmem_wdata; d_resp pulses once.
- Contention with both sides held continuously, STARVE_LIMIT=4 -> grant order D,D,D,D,I,D…; starve_cnt resets after the I grant.
- Reset asserted while in D_RD, pmem_resp arrives 1 cycle after release -> no d_resp, state IDLE, next grant is normal.
- ARB_ROUND_ROBIN_EN defined, both sides always requesting -> grants alternate D,I,D,I over 6 transactions.
